// File: rtl/msg_buffer_ctrl_pkg.sv
// msg_buffer_ctrl_pkg
//   Shared definitions for the message buffer controller: Wishbone cycle-type
//   codes, FSM state encoding and the default burst-length / beat-limit values.
package msg_buffer_ctrl_pkg;

  // Burst-length defaults used across the bus-side blocks.
  localparam int BURST_LEN_BITS_DEF = 5;
  localparam int MAX_BEATS_DEF      = 16;
  localparam int N_BUFFERS_DEF      = 2;
  localparam int N_BITS_BUF_ID_DEF  = 1;

  // Wishbone CTI_I codes.
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  // A classic cycle is a one-beat message, so it terminates like end-of-burst.
  function automatic logic is_msg_end(input logic [2:0] cti);
    return (cti == CTI_EOB) || (cti == CTI_CLASSIC);
  endfunction

endpackage

// File: rtl/msg_buffer_ctrl_rr_arbiter.sv
// rr_arbiter
//   Round-robin selector over N_REQ request lines. The search starts at the
//   index after the last served one. While the presented grant is stalled
//   (valid and not ready) the grant is locked so the consumer sees a stable
//   index even if other requests appear.
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   req_i       : request vector (one bit per buffer)
//   ready_i     : consumer accepts the granted request this cycle
//   valid_o     : at least one request pending
//   grant_o     : index of the granted request
module rr_arbiter #(
  parameter int N_REQ      = 2,
  parameter int N_BITS_IDX = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [N_BITS_IDX-1:0] grant_o
);

  logic [N_BITS_IDX-1:0] ptr_q, ptr_d;
  logic [N_BITS_IDX-1:0] held_q, held_d;
  logic                  lock_q, lock_d;
  logic [N_BITS_IDX-1:0] pick;
  logic                  found;

  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_i[N_BITS_IDX'((int'(ptr_q) + k) % N_REQ)]) begin
        found = 1'b1;
        pick  = N_BITS_IDX'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  assign valid_o = |req_i;
  // A locked grant stays requested until it is accepted, so holding it is safe.
  assign grant_o = lock_q ? held_q : pick;

  always_comb begin
    ptr_d  = ptr_q;
    lock_d = valid_o & ~ready_i;
    held_d = grant_o;
    if (valid_o && ready_i) begin
      ptr_d = N_BITS_IDX'((int'(grant_o) + 1) % N_REQ);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      held_q <= '0;
      lock_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      held_q <= held_d;
      lock_q <= lock_d;
    end
  end

endmodule

// File: rtl/msg_buffer_ctrl.sv
// msg_buffer_ctrl
//   Accepts Wishbone write bursts and steers each message into a free
//   message_buffer instance, then presents completed buffers downstream in
//   round-robin order and clears them once taken.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | no message open; next write beat allocates a free buffer
//   ST_RECEIVE | message open in cur_buf; beats written until end/drop
//   ST_DRAIN   | message hit MAX_BEATS; further beats ACKed and discarded
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   CYC_I/STB_I/WE_I  : Wishbone cycle, strobe, write enable
//   CTI_I             : cycle type (classic / incrementing / end-of-burst)
//   ACK_O             : beat accepted this cycle (combinational)
//   buf_write_o       : one-hot write strobe into the buffer being filled
//   buf_clear_o       : one-hot clear pulse for the buffer being released
//   pkt_valid_o       : some complete message is presented
//   pkt_sel_o         : index of the presented buffer
//   pkt_ready_i       : downstream takes the presented message
//   err_o             : one-cycle pulse on overflow or read access
module msg_buffer_ctrl
  import msg_buffer_ctrl_pkg::*;
#(
  parameter int N_BUFFERS           = N_BUFFERS_DEF,
  parameter int N_BITS_BUF_ID       = N_BITS_BUF_ID_DEF,
  parameter int N_BITS_BURST_LENGHT = BURST_LEN_BITS_DEF,
  parameter int MAX_BEATS           = MAX_BEATS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     CYC_I,
  input  logic                     STB_I,
  input  logic                     WE_I,
  input  logic [2:0]               CTI_I,
  output logic                     ACK_O,
  output logic [N_BUFFERS-1:0]     buf_write_o,
  output logic [N_BUFFERS-1:0]     buf_clear_o,
  output logic                     pkt_valid_o,
  output logic [N_BITS_BUF_ID-1:0] pkt_sel_o,
  input  logic                     pkt_ready_i,
  output logic                     err_o
);

  state_e                         state_q, state_d;
  logic [N_BUFFERS-1:0]           full_q, full_d;
  logic [N_BITS_BUF_ID-1:0]       cur_buf_q, cur_buf_d;
  logic [N_BITS_BURST_LENGHT-1:0] cnt_q, cnt_d;
  logic [N_BITS_BURST_LENGHT-1:0] cnt_inc;

  logic                           beat;
  logic                           msg_end;
  logic                           free_found;
  logic [N_BITS_BUF_ID-1:0]       alloc_idx;
  logic [N_BUFFERS-1:0]           set_full;
  logic [N_BUFFERS-1:0]           clear_vec;
  logic [N_BUFFERS-1:0]           rx_mask;
  logic [N_BUFFERS-1:0]           arb_req;
  logic                           arb_valid;
  logic [N_BITS_BUF_ID-1:0]       arb_grant;
  logic                           accept;
  logic                           ack;
  logic [N_BUFFERS-1:0]           wr;
  logic                           err;

  assign beat    = CYC_I & STB_I;
  assign msg_end = is_msg_end(CTI_I);
  assign cnt_inc = cnt_q + N_BITS_BURST_LENGHT'(1);

  // Lowest-index free buffer. A buffer being cleared this cycle still shows
  // full, so it only becomes allocatable from the next cycle.
  always_comb begin
    free_found = 1'b0;
    alloc_idx  = '0;
    for (int i = N_BUFFERS - 1; i >= 0; i--) begin
      if (!full_q[i]) begin
        free_found = 1'b1;
        alloc_idx  = N_BITS_BUF_ID'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_buf_d = cur_buf_q;
    cnt_d     = cnt_q;
    set_full  = '0;
    ack       = 1'b0;
    wr        = '0;
    err       = 1'b0;

    if (beat && !WE_I) begin
      // Reads are not supported: complete the cycle but flag it.
      ack = 1'b1;
      err = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (beat && free_found) begin
            ack            = 1'b1;
            wr[alloc_idx]  = 1'b1;
            cur_buf_d      = alloc_idx;
            cnt_d          = N_BITS_BURST_LENGHT'(1);
            if (msg_end) begin
              set_full[alloc_idx] = 1'b1;
            end else begin
              state_d = ST_RECEIVE;
            end
          end
        end

        ST_RECEIVE: begin
          if (!CYC_I) begin
            // Aborted burst: keep what arrived as a short message.
            set_full[cur_buf_q] = 1'b1;
            cnt_d               = '0;
            state_d             = ST_IDLE;
          end else if (beat) begin
            ack           = 1'b1;
            wr[cur_buf_q] = 1'b1;
            cnt_d         = cnt_inc;
            if (msg_end) begin
              set_full[cur_buf_q] = 1'b1;
              cnt_d               = '0;
              state_d             = ST_IDLE;
            end else if (cnt_inc == N_BITS_BURST_LENGHT'(MAX_BEATS)) begin
              set_full[cur_buf_q] = 1'b1;
              err                 = 1'b1;
              cnt_d               = '0;
              state_d             = ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          if (!CYC_I) begin
            state_d = ST_IDLE;
          end else if (beat) begin
            ack = 1'b1;
            if (msg_end) begin
              state_d = ST_IDLE;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // The buffer being filled is never offered downstream.
  always_comb begin
    rx_mask = '0;
    if (state_q == ST_RECEIVE) begin
      rx_mask[cur_buf_q] = 1'b1;
    end
  end

  assign arb_req = full_q & ~rx_mask;

  rr_arbiter #(
    .N_REQ      (N_BUFFERS),
    .N_BITS_IDX (N_BITS_BUF_ID)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req_i   (arb_req),
    .ready_i (pkt_ready_i),
    .valid_o (arb_valid),
    .grant_o (arb_grant)
  );

  assign accept = arb_valid & pkt_ready_i & ~rst;

  always_comb begin
    clear_vec = '0;
    if (rst) begin
      clear_vec = '1;
    end else if (accept) begin
      clear_vec[arb_grant] = 1'b1;
    end
  end

  assign full_d = (full_q & ~clear_vec) | set_full;

  assign ACK_O       = ack & ~rst;
  assign buf_write_o = rst ? '0 : wr;
  assign err_o       = err & ~rst;
  assign pkt_valid_o = arb_valid & ~rst;
  assign pkt_sel_o   = arb_grant;
  assign buf_clear_o = clear_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      full_q    <= '0;
      cur_buf_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      cur_buf_q <= cur_buf_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_msg_buffer_ctrl.sv
// tb_msg_buffer_ctrl
//   Directed bench for msg_buffer_ctrl with a message-level reference model
//   compared on every falling edge, plus literal expectations per scenario.
module tb_msg_buffer_ctrl;
  import msg_buffer_ctrl_pkg::*;

  localparam int N    = 2;
  localparam int MAXB = 16;
  localparam int M_IDLE = 0;
  localparam int M_RX   = 1;
  localparam int M_DROP = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cyc = 1'b0;
  logic         stb = 1'b0;
  logic         we  = 1'b0;
  logic [2:0]   cti = 3'b000;
  logic         rdy = 1'b0;
  logic         ack;
  logic [N-1:0] wr;
  logic [N-1:0] clr;
  logic         pv;
  logic [0:0]   sel;
  logic         err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  msg_buffer_ctrl #(
    .N_BUFFERS           (N),
    .N_BITS_BUF_ID       (1),
    .N_BITS_BURST_LENGHT (5),
    .MAX_BEATS           (MAXB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .CYC_I       (cyc),
    .STB_I       (stb),
    .WE_I        (we),
    .CTI_I       (cti),
    .ACK_O       (ack),
    .buf_write_o (wr),
    .buf_clear_o (clr),
    .pkt_valid_o (pv),
    .pkt_sel_o   (sel),
    .pkt_ready_i (rdy),
    .err_o       (err)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffers as full bits, one open message, round-robin
  // pointer and the index held while the consumer stalls.
  bit full_m [N];
  int ptr_m  = 0;
  int held_m = -1;
  int cur_m  = 0;
  int nb_m   = 0;
  int mode_m = M_IDLE;

  always @(negedge clk) begin : model_cmp
    int e_ack, e_wr, e_clr, e_pv, e_err, e_sel, done, freeb;
    bit beat, fin;
    e_ack = 0; e_wr = 0; e_clr = 0; e_pv = 0; e_err = 0; e_sel = 0;
    done = -1; freeb = -1;
    beat = cyc && stb;
    fin  = (cti == 3'b111) || (cti == 3'b000);
    if (rst) begin
      e_clr  = (1 << N) - 1;
      ptr_m  = 0; held_m = -1; cur_m = 0; nb_m = 0; mode_m = M_IDLE;
      for (int j = 0; j < N; j++) full_m[j] = 1'b0;
    end else begin
      for (int j = 0; j < N; j++) if (full_m[j]) e_pv = 1;
      if (e_pv) begin
        if (held_m >= 0) e_sel = held_m;
        else begin
          for (int k = N - 1; k >= 0; k--)
            if (full_m[(ptr_m + k) % N]) e_sel = (ptr_m + k) % N;
        end
      end
      if (beat && !we) begin
        e_ack = 1; e_err = 1;
      end else if (mode_m == M_IDLE) begin
        if (beat) begin
          for (int j = N - 1; j >= 0; j--) if (!full_m[j]) freeb = j;
          if (freeb >= 0) begin
            e_ack = 1; e_wr = 1 << freeb; cur_m = freeb; nb_m = 1;
            if (fin) done = freeb;
            else mode_m = M_RX;
          end
        end
      end else if (mode_m == M_RX) begin
        if (!cyc) begin
          done = cur_m; mode_m = M_IDLE;
        end else if (beat) begin
          e_ack = 1; e_wr = 1 << cur_m; nb_m++;
          if (fin) begin
            done = cur_m; mode_m = M_IDLE;
          end else if (nb_m == MAXB) begin
            done = cur_m; e_err = 1; mode_m = M_DROP;
          end
        end
      end else begin
        if (!cyc) mode_m = M_IDLE;
        else if (beat) begin
          e_ack = 1;
          if (fin) mode_m = M_IDLE;
        end
      end
      if (e_pv && rdy) begin
        e_clr = 1 << e_sel; full_m[e_sel] = 1'b0;
        ptr_m = (e_sel + 1) % N; held_m = -1;
      end else begin
        held_m = e_pv ? e_sel : -1;
      end
      if (done >= 0) full_m[done] = 1'b1;
    end
    chk("m_ack", ack, e_ack);
    chk("m_wr", wr, e_wr);
    chk("m_clr", clr, e_clr);
    chk("m_pv", pv, e_pv);
    chk("m_err", err, e_err);
    if (e_pv) chk("m_sel", sel, e_sel);
  end

  task automatic drive(input bit c, input bit s, input bit w, input logic [2:0] t,
                       input bit r, input bit rs);
    @(posedge clk);
    #1;
    cyc = c; stb = s; we = w; cti = t; rdy = r; rst = rs;
    @(negedge clk);
  endtask

  task automatic idle(input bit r);
    drive(1'b0, 1'b0, 1'b1, CTI_CLASSIC, r, 1'b0);
  endtask

  task automatic reset_cycle();
    drive(1'b0, 1'b0, 1'b1, CTI_CLASSIC, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr;
    // Reset values and single 4-beat burst.
    reset_cycle();
    chk("rst_ack", ack, 0); chk("rst_clr", clr, 3); chk("rst_pv", pv, 0);
    chk("rst_wr", wr, 0);   chk("rst_err", err, 0);
    idle(1'b0);
    chk("idle_pv", pv, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, (i == 3) ? CTI_EOB : CTI_INCR, 1'b0, 1'b0);
      chk("b1_ack", ack, 1); chk("b1_wr", wr, 1);
    end
    idle(1'b0);
    chk("b1_pv", pv, 1); chk("b1_sel", sel, 0); chk("b1_wr_idle", wr, 0);

    // Second burst fills buffer 1; third stalls until buffer 0 is taken.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, (i == 3) ? CTI_EOB : CTI_INCR, 1'b0, 1'b0);
      chk("b2_ack", ack, 1); chk("b2_wr", wr, 2);
    end
    idle(1'b0);
    chk("b2_pv", pv, 1); chk("b2_sel", sel, 0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, CTI_INCR, 1'b0, 1'b0);
      chk("b3_wait_ack", ack, 0); chk("b3_wait_wr", wr, 0);
    end
    drive(1'b1, 1'b1, 1'b1, CTI_INCR, 1'b1, 1'b0);
    chk("b3_clr_ack", ack, 0); chk("b3_clr", clr, 1); chk("b3_clr_sel", sel, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, (i == 3) ? CTI_EOB : CTI_INCR, 1'b0, 1'b0);
      chk("b3_ack", ack, 1); chk("b3_wr", wr, 1);
    end
    idle(1'b0);
    chk("b3_pv", pv, 1); chk("b3_sel", sel, 1);

    // Both full, consumer always ready: 0 then 1.
    reset_cycle();
    chk("r2_clr", clr, 3);
    drive(1'b1, 1'b1, 1'b1, CTI_CLASSIC, 1'b0, 1'b0);
    chk("c1_wr", wr, 1); chk("c1_ack", ack, 1);
    drive(1'b1, 1'b1, 1'b1, CTI_CLASSIC, 1'b0, 1'b0);
    chk("c2_wr", wr, 2); chk("c2_pv", pv, 1); chk("c2_sel", sel, 0);
    idle(1'b1);
    chk("rr0_sel", sel, 0); chk("rr0_clr", clr, 1);
    idle(1'b1);
    chk("rr1_sel", sel, 1); chk("rr1_clr", clr, 2);
    idle(1'b1);
    chk("rr_empty_pv", pv, 0); chk("rr_empty_clr", clr, 0);

    // Overflow: 20 beats with a 16-beat limit.
    reset_cycle();
    nwr = 0;
    for (int b = 1; b <= 20; b++) begin
      drive(1'b1, 1'b1, 1'b1, (b == 20) ? CTI_EOB : CTI_INCR, 1'b0, 1'b0);
      chk("ov_ack", ack, 1);
      chk("ov_err", err, (b == 16) ? 1 : 0);
      if (wr != 0) nwr++;
      if (b > 16) chk("ov_drain_wr", wr, 0);
    end
    chk("ov_writes", nwr, 16);
    idle(1'b0);
    chk("ov_pv", pv, 1); chk("ov_sel", sel, 0);

    // Read beat in IDLE.
    drive(1'b1, 1'b1, 1'b0, CTI_CLASSIC, 1'b0, 1'b0);
    chk("rd_ack", ack, 1); chk("rd_wr", wr, 0); chk("rd_err", err, 1);
    idle(1'b0);
    chk("rd_err_after", err, 0); chk("rd_ack_after", ack, 0);

    // Reset after beat 2 of 4; the rest becomes a new message in buffer 0.
    reset_cycle();
    drive(1'b1, 1'b1, 1'b1, CTI_INCR, 1'b0, 1'b0);
    chk("mr_b1_wr", wr, 1);
    drive(1'b1, 1'b1, 1'b1, CTI_INCR, 1'b0, 1'b0);
    chk("mr_b2_wr", wr, 1);
    drive(1'b1, 1'b1, 1'b1, CTI_INCR, 1'b0, 1'b1);
    chk("mr_rst_ack", ack, 0); chk("mr_rst_clr", clr, 3);
    chk("mr_rst_wr", wr, 0);   chk("mr_rst_pv", pv, 0);
    drive(1'b1, 1'b1, 1'b1, CTI_INCR, 1'b0, 1'b0);
    chk("mr_b3_wr", wr, 1); chk("mr_b3_ack", ack, 1); chk("mr_b3_pv", pv, 0);
    drive(1'b1, 1'b1, 1'b1, CTI_EOB, 1'b0, 1'b0);
    chk("mr_b4_wr", wr, 1);
    idle(1'b0);
    chk("mr_pv", pv, 1); chk("mr_sel", sel, 0);

    // CYC_I dropped mid-burst closes the message in buffer 1.
    drive(1'b1, 1'b1, 1'b1, CTI_INCR, 1'b0, 1'b0);
    chk("ab_b1_wr", wr, 2);
    drive(1'b1, 1'b1, 1'b1, CTI_INCR, 1'b0, 1'b0);
    chk("ab_b2_wr", wr, 2);
    drive(1'b0, 1'b0, 1'b1, CTI_INCR, 1'b0, 1'b0);
    chk("ab_drop_wr", wr, 0); chk("ab_drop_sel", sel, 0);
    idle(1'b1);
    chk("ab_rr0_sel", sel, 0); chk("ab_rr0_clr", clr, 1);
    idle(1'b1);
    chk("ab_rr1_sel", sel, 1); chk("ab_rr1_clr", clr, 2);
    idle(1'b0);
    chk("ab_empty_pv", pv, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msg_buffer_ctrl.md
MSG_BUFFER_CTRL -- requirements
Module: msg_buffer_ctrl

Interface
REQ-001 Parameter N_BUFFERS, default 2: number of message_buffer instances controlled.
REQ-002 Parameter N_BITS_BUF_ID, default 1: width of buffer index, equal to ceil(log2(N_BUFFERS)).
REQ-003 Parameter N_BITS_BURST_LENGHT, default 5: beat-counter width.
REQ-004 Parameter MAX_BEATS, default 16: maximum beats stored per message.
REQ-005 clk  in  1  clock, all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 CYC_I  in  1  bus cycle active.
REQ-008 STB_I  in  1  bus strobe, beat offered.
REQ-009 WE_I  in  1  write (1) / read (0).
REQ-010 CTI_I  in  3  cycle type: 3'b000 classic, 3'b010 incrementing burst, 3'b111 end-of-burst.
REQ-011 ACK_O  out  1  beat accepted this cycle.
REQ-012 buf_write_o  out  N_BUFFERS  one-hot per-buffer is_valid_i strobe.
REQ-013 buf_clear_o  out  N_BUFFERS  one-hot per-buffer clear_buffer_i pulse.
REQ-014 pkt_valid_o  out  1  a complete message is presented downstream.
REQ-015 pkt_sel_o  out  N_BITS_BUF_ID  index of the buffer whose pkt_o is presented.
REQ-016 pkt_ready_i  in  1  downstream accepts the presented packet.
REQ-017 err_o  out  1  one-cycle pulse on protocol error (overflow or read).

Function
REQ-018 Beat = CYC_I & STB_I; FSM states IDLE, RECEIVE, DRAIN.
REQ-019 Per-buffer registered full flag; a buffer is free when its flag is 0.
REQ-020 IDLE, write beat, any free buffer: lowest-index free buffer allocated (cur_buf registered), beat written, ACK_O=1, beat count=1, next state RECEIVE unless the beat ends the message.
REQ-021 IDLE, write beat, no free buffer: ACK_O=0, no write, wait states inserted until a buffer frees.
REQ-022 ACK_O and buf_write_o[cur_buf] combinational, asserted in the same cycle as the accepted beat.
REQ-023 Message end: beat with CTI_I=3'b111 or 3'b000; that beat is written, cur_buf full set next edge, return to IDLE.
REQ-024 RECEIVE, CYC_I deasserted before end beat: cur_buf marked full with beats received so far, return to IDLE.
REQ-025 Beat count reaches MAX_BEATS without end beat: that beat written, buffer marked full, err_o pulses, next state DRAIN.
REQ-026 DRAIN: beats ACKed and discarded (buf_write_o=0) until end beat or CYC_I low, then IDLE.
REQ-027 Read beat (WE_I=0) in any state: ACK_O=1, no write, err_o pulse, FSM state unchanged.
REQ-028 Output arbitration round-robin over full buffers, starting after last served index.
REQ-029 pkt_valid_o = any buffer full; pkt_sel_o held stable while pkt_valid_o=1 and pkt_ready_i=0.
REQ-030 pkt_valid_o & pkt_ready_i: buf_clear_o[pkt_sel_o] pulses that cycle, full flag cleared next edge, round-robin pointer = pkt_sel_o+1 modulo N_BUFFERS.
REQ-031 Buffer freed in cycle t is allocatable from cycle t+1 only; allocation never targets a buffer being cleared.
REQ-032 The buffer currently receiving is never presented downstream.

Reset
REQ-033 On rst: state IDLE, all full flags 0, beat count 0, round-robin pointer 0, cur_buf 0.
REQ-034 During rst cycle: ACK_O, buf_write_o, pkt_valid_o, err_o = 0; buf_clear_o = all ones.
REQ-035 rst mid-burst: partial message discarded; remaining beats after reset treated as a new message.

Structure
REQ-036 Shared package/defines: CTI codes, FSM state encoding, MAX_BEATS default alongside existing burst-length defines.
REQ-037 One sub-module rr_arbiter (N_BUFFERS requests, grant index, lock-while-stalled) for output selection.

Verification
REQ-038 4-beat burst (CTI 010,010,010,111), both free -> buf_write_o=01 for 4 cycles, ACK each, pkt_valid_o=1, pkt_sel_o=0 next cycle.
REQ-039 Two back-to-back bursts, pkt_ready_i=0 -> buffers 0,1 full; third burst ACK_O=0 until pkt_ready_i=1 clears buffer 0, then third written to buffer 0.
REQ-040 Both full, pkt_ready_i=1 continuous -> pkt_sel_o 0 then 1, buf_clear_o 01 then 10.
REQ-041 20-beat burst, MAX_BEATS=16 -> 16 writes, err_o pulse on beat 16, beats 17-20 ACKed unwritten.
REQ-042 Read beat in IDLE -> ACK_O=1, buf_write_o=00, err_o=1 one cycle.
REQ-043 rst asserted after beat 2 of 4 -> full flags 00, buf_clear_o=11, next burst lands in buffer 0.
